// File: rtl/alu_seq_param_if.sv
// Request/result bundle for alu_seq_param: operand side (valid_i/ready_o)
// and result side (valid_o/ready_i) handshakes plus the result payload.
interface alu_seq_param_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [3:0]       op_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] alu_o;
  logic [WIDTH-1:0] alu_hi_o;
  logic             zero_o;
  logic             neg_o;
  logic             carry_o;
  logic             ovf_o;
  logic             err_o;
  logic             valid_o;
  logic             ready_i;

  // The ALU itself.
  modport slave (
    input  a_i, b_i, op_i, valid_i, ready_i,
    output ready_o, alu_o, alu_hi_o, zero_o, neg_o, carry_o, ovf_o, err_o, valid_o
  );

  // The issuing stage and result consumer.
  modport master (
    output a_i, b_i, op_i, valid_i, ready_i,
    input  ready_o, alu_o, alu_hi_o, zero_o, neg_o, carry_o, ovf_o, err_o, valid_o
  );
endinterface

// File: rtl/alu_seq_param.sv
// Parametrised registered ALU with status flags, a WIDTH-step shift-add
// multiplier and valid/ready handshakes on both the request and result side.
// Results live in one output register until the consumer takes them.
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             reset_n,
  alu_seq_param_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, LOAD} state_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic err;
  } flags_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   alu_q, alu_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  flags_t             flags_q, flags_d;

  logic [WIDTH-1:0]   res_alu;
  flags_t             res_flags;
  flags_t             mul_flags;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [WIDTH:0]     step_sum;
  logic [CW-1:0]      sh;
  logic               accept;

  // ready_o never looks at valid_i, so the issuer can wait on it safely.
  assign bus.ready_o = (state_q == IDLE) && (!valid_q || bus.ready_i);
  assign accept      = bus.valid_i && bus.ready_o;

  // Single-cycle result and flags for every opcode except MUL.
  always_comb begin
    sum_w     = {1'b0, bus.a_i} + {1'b0, bus.b_i};
    diff_w    = {1'b0, bus.a_i} - {1'b0, bus.b_i};
    sh        = bus.b_i[CW-1:0];
    res_alu   = '0;
    res_flags = '0;
    case (bus.op_i)
      4'd0: begin
        res_alu         = sum_w[WIDTH-1:0];
        res_flags.carry = sum_w[WIDTH];
        res_flags.ovf   = (bus.a_i[WIDTH-1] == bus.b_i[WIDTH-1]) &&
                          (sum_w[WIDTH-1] != bus.a_i[WIDTH-1]);
      end
      4'd1: begin
        res_alu         = diff_w[WIDTH-1:0];
        res_flags.carry = diff_w[WIDTH];
        res_flags.ovf   = (bus.a_i[WIDTH-1] != bus.b_i[WIDTH-1]) &&
                          (diff_w[WIDTH-1] != bus.a_i[WIDTH-1]);
      end
      4'd2:    res_alu = bus.a_i << sh;
      4'd3:    res_alu = bus.a_i >> sh;
      4'd4:    res_alu = bus.a_i & bus.b_i;
      4'd5:    res_alu = bus.a_i | bus.b_i;
      4'd6:    res_alu = bus.a_i ^ bus.b_i;
      4'd7:    res_alu = {{(WIDTH-1){1'b0}}, (bus.a_i == bus.b_i)};
      4'd8:    res_alu = '0;
      default: res_flags.err = 1'b1;
    endcase
    if (!res_flags.err) begin
      res_flags.zero = (res_alu == '0);
      res_flags.neg  = res_alu[WIDTH-1];
    end
  end

  // One multiplier step and the flags of the finished product.
  always_comb begin
    step_sum        = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (mplier_q[0] ? {1'b0, mcand_q} : '0);
    mul_flags       = '0;
    mul_flags.zero  = (acc_q[WIDTH-1:0] == '0);
    mul_flags.neg   = acc_q[WIDTH-1];
    mul_flags.carry = |acc_q[2*WIDTH-1:WIDTH];
  end

  // Sequencer: accept requests, run the multiplier, manage the result register.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    valid_d  = valid_q;
    alu_d    = alu_q;
    hi_d     = hi_q;
    flags_d  = flags_q;
    if (valid_q && bus.ready_i) begin
      valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.op_i == 4'd8) begin
            mcand_d  = bus.a_i;
            mplier_d = bus.b_i;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            alu_d   = res_alu;
            hi_d    = '0;
            flags_d = res_flags;
            valid_d = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = {step_sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!valid_q || bus.ready_i) begin
          alu_d   = acc_q[WIDTH-1:0];
          hi_d    = acc_q[2*WIDTH-1:WIDTH];
          flags_d = mul_flags;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset discards any multiply in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      valid_q  <= 1'b0;
      alu_q    <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      valid_q  <= valid_d;
      alu_q    <= alu_d;
      hi_q     <= hi_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.valid_o  = valid_q;
  assign bus.alu_o    = alu_q;
  assign bus.alu_hi_o = hi_q;
  assign bus.zero_o   = flags_q.zero;
  assign bus.neg_o    = flags_q.neg;
  assign bus.carry_o  = flags_q.carry;
  assign bus.ovf_o    = flags_q.ovf;
  assign bus.err_o    = flags_q.err;
endmodule
